// File: rtl/sfx_pkg.sv
// Shared encodings and tone table for the sound-effect scheduler.
// Tone ids are ordered by priority so a plain magnitude compare decides preemption.
package sfx_pkg;

  typedef logic [15:0]        cnt_t;
  typedef logic signed [23:0] sample_t;

  typedef enum logic [1:0] {
    TONE_NONE  = 2'd0,
    TONE_MOVE  = 2'd1,
    TONE_SCORE = 2'd2,
    TONE_CRASH = 2'd3
  } tone_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  localparam cnt_t    HP_MOVE   = 16'd48;
  localparam cnt_t    HP_SCORE  = 16'd24;
  localparam cnt_t    HP_CRASH  = 16'd120;
  localparam cnt_t    DUR_MOVE  = 16'd2400;
  localparam cnt_t    DUR_SCORE = 16'd4800;
  localparam cnt_t    DUR_CRASH = 16'd24000;
  localparam cnt_t    GAP_LEN   = 16'd240;
  localparam sample_t AMP       = 24'sh100000;

  function automatic cnt_t hp_of(input tone_e t);
    case (t)
      TONE_MOVE:  return HP_MOVE;
      TONE_SCORE: return HP_SCORE;
      TONE_CRASH: return HP_CRASH;
      default:    return 16'd1;
    endcase
  endfunction

  function automatic cnt_t dur_of(input tone_e t);
    case (t)
      TONE_MOVE:  return DUR_MOVE;
      TONE_SCORE: return DUR_SCORE;
      TONE_CRASH: return DUR_CRASH;
      default:    return '0;
    endcase
  endfunction

  // Pending vector layout: bit0 move, bit1 score, bit2 crash.
  function automatic logic [2:0] tone_bit(input tone_e t);
    case (t)
      TONE_MOVE:  return 3'b001;
      TONE_SCORE: return 3'b010;
      TONE_CRASH: return 3'b100;
      default:    return 3'b000;
    endcase
  endfunction

  function automatic tone_e pick(input logic [2:0] p);
    if (p[2])      return TONE_CRASH;
    else if (p[1]) return TONE_SCORE;
    else if (p[0]) return TONE_MOVE;
    else           return TONE_NONE;
  endfunction

endpackage

// File: rtl/sfx_scheduler_if.sv
// Codec sample handshake between the scheduler (master) and the audio codec (slave).
interface sfx_scheduler_if;
  import sfx_pkg::*;

  logic    write_ready;
  logic    write;
  sample_t writedata_left;
  sample_t writedata_right;

  modport master (
    input  write_ready,
    output write, writedata_left, writedata_right
  );

  modport slave (
    output write_ready,
    input  write, writedata_left, writedata_right
  );
endinterface

// File: rtl/sfx_tone_gen.sv
// Square-wave generator: phase counter and polarity, registered signed sample output.
module sfx_tone_gen
  import sfx_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  logic    start,
  input  cnt_t    half_period,
  input  logic    advance,
  input  logic    enable,
  output sample_t sample
);

  cnt_t    phase_q, phase_d;
  logic    pol_q, pol_d;
  sample_t sample_q, sample_d;

  always_comb begin
    phase_d = phase_q;
    pol_d   = pol_q;
    if (start) begin
      phase_d = '0;
      pol_d   = 1'b1;
    end else if (advance) begin
      if ({1'b0, phase_q} + 17'd1 >= {1'b0, half_period}) begin
        phase_d = '0;
        pol_d   = ~pol_q;
      end else begin
        phase_d = phase_q + 16'd1;
      end
    end
    // Built from next-cycle polarity so the register holds the sample of the current state.
    sample_d = enable ? (pol_d ? AMP : -AMP) : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q  <= '0;
      pol_q    <= 1'b1;
      sample_q <= '0;
    end else begin
      phase_q  <= phase_d;
      pol_q    <= pol_d;
      sample_q <= sample_d;
    end
  end

  assign sample = sample_q;

endmodule

// File: rtl/sfx_scheduler.sv
// Sound-effect scheduler: arbitrates move/score/crash requests and streams tone
// samples to the codec, one per write handshake, with a silent gap between tones.
module sfx_scheduler
  import sfx_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_move,
  input  logic                   req_score,
  input  logic                   req_crash,
  input  logic                   mute,
  sfx_scheduler_if.master        codec,
  output logic                   busy,
  output logic [1:0]             active_id
);

  state_e     state_q, state_d;
  tone_e      active_q, active_d;
  tone_e      want;
  cnt_t       dur_q, dur_d, gap_q, gap_d;
  logic [2:0] pend_q, pend_d, req;
  logic       write_q, write_d;
  logic       busy_q, busy_d;
  logic       launch, tone_start, tone_en;
  sample_t    sample;

  always_comb begin
    req        = {req_crash, req_score, req_move};
    state_d    = state_q;
    active_d   = active_q;
    dur_d      = dur_q;
    gap_d      = gap_q;
    launch     = 1'b0;
    tone_start = 1'b0;
    write_d    = codec.write_ready & ~write_q;
    pend_d     = pend_q | req;
    want       = pick(pend_d);

    case (state_q)
      ST_IDLE: launch = (want != TONE_NONE);
      ST_PLAY: begin
        // End of tone wins so a request in that same cycle is held for after the gap.
        if (write_q && dur_q <= 16'd1) begin
          state_d  = ST_GAP;
          active_d = TONE_NONE;
          dur_d    = '0;
          gap_d    = GAP_LEN;
        end else if (want > active_q) begin
          launch = 1'b1;
        end else if (|(req & tone_bit(active_q))) begin
          dur_d      = dur_of(active_q);
          tone_start = 1'b1;
          pend_d     = pend_d & ~tone_bit(active_q);
        end else if (write_q) begin
          dur_d = dur_q - 16'd1;
        end
      end
      ST_GAP: begin
        if (write_q) begin
          if (gap_q <= 16'd1) begin
            gap_d = '0;
            if (want != TONE_NONE) launch  = 1'b1;
            else                   state_d = ST_IDLE;
          end else begin
            gap_d = gap_q - 16'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (launch) begin
      state_d    = ST_PLAY;
      active_d   = want;
      dur_d      = dur_of(want);
      tone_start = 1'b1;
      pend_d     = pend_d & ~tone_bit(want);
    end

    busy_d  = (state_d != ST_IDLE);
    tone_en = (state_d == ST_PLAY) && !mute;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      active_q <= TONE_NONE;
      dur_q    <= '0;
      gap_q    <= '0;
      pend_q   <= '0;
      write_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
      dur_q    <= dur_d;
      gap_q    <= gap_d;
      pend_q   <= pend_d;
      write_q  <= write_d;
      busy_q   <= busy_d;
    end
  end

  sfx_tone_gen u_tone (
    .clk         (clk),
    .reset       (reset),
    .start       (tone_start),
    .half_period (hp_of(active_q)),
    .advance     (write_q),
    .enable      (tone_en),
    .sample      (sample)
  );

  assign codec.write           = write_q;
  assign codec.writedata_left  = sample;
  assign codec.writedata_right = sample;
  assign busy                  = busy_q;
  assign active_id             = active_q;

endmodule

// File: doc/sfx_scheduler.md
SFX_SCHEDULER -- requirements
Module: sfx_scheduler

Interface
REQ-001 The block SHALL have ports `clk`, input, 1 bit: the system clock (CLOCK_50 domain, shared with audio_codec).
REQ-002 The block SHALL have port `reset`, input, 1 bit: synchronous, active-high reset.
REQ-003 The block SHALL have ports `req_move`, `req_score` and `req_crash`, input, 1 bit each: single-cycle request pulses.
REQ-004 The block SHALL have port `mute`, input, 1 bit: when high, output samples are forced to zero and all timing continues.
REQ-005 The block SHALL have port `write_ready`, input, 1 bit: the codec can accept one sample.
REQ-006 The block SHALL have port `write`, output, 1 bit: sample strobe to the codec.
REQ-007 The block SHALL have ports `writedata_left` and `writedata_right`, output, 24 bits each: signed sample, with the same value on both.
REQ-008 The block SHALL have port `busy`, output, 1 bit: high in PLAY or GAP.
REQ-009 The block SHALL have port `active_id`, output, 2 bits: 0 none, 1 move, 2 score, 3 crash.
REQ-010 The tone parameters SHALL be: `HP_MOVE`=48, `HP_SCORE`=24, `HP_CRASH`=120 (half-period, in samples).
REQ-011 The duration parameters SHALL be: `DUR_MOVE`=2400, `DUR_SCORE`=4800, `DUR_CRASH`=24000 (in samples).
REQ-012 The remaining parameters SHALL be: `GAP_LEN`=240 (in samples) and `AMP`=24'h100000.

Function
REQ-013 Each request pulse SHALL set its pending bit.
REQ-014 A pending bit SHALL clear in the cycle its tone starts.
REQ-015 Priority SHALL be fixed, highest first: crash, then score, then move.
REQ-016 The state machine SHALL have the states IDLE, PLAY and GAP.
REQ-017 Transition from IDLE: any pending bit set -> PLAY with the highest-priority pending tone, the duration count loaded, and the phase count at 0 with the output in the positive half.
REQ-018 Transition from PLAY: duration count reaches 0 -> GAP with the GAP_LEN count loaded.
REQ-019 Transition from GAP: count reaches 0 -> PLAY if any pending bit is set, otherwise IDLE.
REQ-020 Preemption: a pending tone of higher priority than the active one SHALL start immediately in the next cycle (no GAP), and the preempted tone SHALL be dropped.
REQ-021 A request for the active tone id SHALL restart that tone's duration and phase and SHALL NOT set its pending bit.
REQ-022 A lower-priority request during PLAY SHALL stay pending until after GAP.
REQ-023 Simultaneous requests SHALL start the highest-priority tone; the others SHALL remain pending.
REQ-024 A request arriving in the same cycle the duration reaches 0 SHALL be latched as pending, SHALL NOT be lost, and SHALL be served after GAP.
REQ-025 Handshake: `write` SHALL be registered and SHALL be asserted for exactly one cycle when `write_ready` is sampled high and `write` is low.
REQ-026 There SHALL be no back-to-back `write` pulses.
REQ-027 `writedata` SHALL be stable in the cycle `write` is high.
REQ-028 Writes SHALL continue in IDLE and GAP with zero data so the codec FIFO never underruns.
REQ-029 All counters (duration, phase, gap) SHALL decrement only on cycles with `write`=1.
REQ-030 The phase count SHALL toggle the polarity and reload after HP samples of the active tone.
REQ-031 Sample value in PLAY SHALL be +AMP (24'h100000) or -AMP (24'hF00000), and SHALL be 0 in IDLE, in GAP, or when `mute`=1.
REQ-032 Counters SHALL be unsigned, 16 bits wide, with no wrap-around; a counter at 0 SHALL never decrement.
REQ-033 `busy` and `active_id` SHALL be registered and SHALL track the state one cycle after the transition.

Reset
REQ-034 While `reset`=1 the block SHALL enter IDLE and clear all pending bits and counters.
REQ-035 While `reset`=1 the outputs SHALL be `write`=0, `writedata_left`/`writedata_right`=0, `busy`=0 and `active_id`=0.
REQ-036 Reset asserted mid-PLAY SHALL abort the tone with no further non-zero sample.
REQ-037 Requests during reset SHALL be ignored.

Structure
REQ-038 The shared package `sfx_pkg` SHALL hold the tone-id encoding (NONE, MOVE, SCORE, CRASH), the HP/DUR table constants, GAP_LEN, AMP, and the state encoding.
REQ-039 One sub-module, `sfx_tone_gen`, SHALL hold the phase counter and polarity and produce the signed sample.
REQ-040 `sfx_tone_gen` SHALL have the inputs: clk, reset, start (reload), half_period, advance (=write) and enable.

Verification
REQ-041 Single tone: `write_ready` high every 4th cycle, `req_score` pulse -> `active_id`=2, 4800 written samples alternating 24 positive / 24 negative, then 240 zero samples, then IDLE with `busy`=0.
REQ-042 Priority: `req_move` and `req_crash` in the same cycle -> crash plays for 24000 samples, then GAP of 240, then move plays for 2400 samples.
REQ-043 Preemption: `req_crash` at sample 1000 of a score tone -> the next sample starts crash at +AMP with no gap, and the score tone is never resumed.
REQ-044 Retrigger: `req_move` at sample 2000 of a move tone -> 2400 further move samples, with no pending move afterward.
REQ-045 Mute / backpressure: `mute`=1 during crash -> all samples 0 but still 24000 + 240 writes; `write_ready` held low for 100 cycles -> no `write` and the counters frozen.
REQ-046 Reset: `reset` pulse mid-PLAY -> the next cycle has `write`=0, `active_id`=0 and no pending bits; a subsequent `req_move` plays normally.
